// File: rtl/reflet_float_latency_tracker.sv
// Multi-channel FPU latency tracker: each channel raises ready a programmable
// number of cycles after its operation is triggered (operand change or start strobe).
module reflet_float_latency_tracker #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned INPUT_SIZE   = 16,
   parameter int unsigned MAX_LATENCY  = 8,
   parameter int unsigned TRIGGER_MODE = 0,
   localparam int unsigned LAT_W       = $clog2(MAX_LATENCY + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            enable,
   input  logic [CHANNELS-1:0]            start,
   input  logic [CHANNELS*INPUT_SIZE-1:0] in,
   input  logic [CHANNELS*LAT_W-1:0]      latency,
   output logic [CHANNELS-1:0]            ready,
   output logic [CHANNELS-1:0]            done,
   output logic [CHANNELS-1:0]            busy,
   output logic                           all_ready,
   output logic                           any_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      READY = 2'd2
   } state_t;

   localparam bit             MODE_START = (TRIGGER_MODE == 1);
   localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LATENCY);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t                  state;
      logic [LAT_W-1:0]        cnt;
      logic [LAT_W-1:0]        lat_q;
      logic [INPUT_SIZE-1:0]   prev_in;
      logic                    en_q;
      logic                    ready_q;
      logic                    done_q;
      logic                    busy_q;

      logic [INPUT_SIZE-1:0]   in_c;
      logic [LAT_W-1:0]        lat_req_c;
      logic [LAT_W-1:0]        lat_clamp_c;
      logic                    trig_c;

      // Trigger detection and requested-latency clamp (0 behaves as 1)
      always_comb begin
         in_c        = in[c*INPUT_SIZE +: INPUT_SIZE];
         lat_req_c   = latency[c*LAT_W +: LAT_W];
         lat_clamp_c = lat_req_c;
         if (lat_req_c > LAT_MAX) begin
            lat_clamp_c = LAT_MAX;
         end else if (lat_req_c == '0) begin
            lat_clamp_c = LAT_ONE;
         end
         trig_c = enable[c] & (MODE_START ? start[c] : ((in_c != prev_in) | ~en_q));
      end

      // Channel FSM; enable low dominates trigger, trigger dominates counting
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_q   <= '0;
            prev_in <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            prev_in <= in_c;
            en_q    <= enable[c];
            if (!enable[c]) begin
               state   <= IDLE;
               cnt     <= '0;
               ready_q <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end else if (trig_c) begin
               state   <= COUNT;
               lat_q   <= lat_clamp_c;
               cnt     <= LAT_ONE;
               ready_q <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b1;
            end else begin
               case (state)
                  COUNT: begin
                     if (cnt >= lat_q) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        cnt <= cnt + LAT_ONE;
                     end
                  end
                  READY: begin
                     done_q <= 1'b0;
                  end
                  default: begin
                     state   <= IDLE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign ready[c] = ready_q;
      assign done[c]  = done_q;
      assign busy[c]  = busy_q;
   end

   assign all_ready = &ready;
   assign any_ready = |ready;

endmodule

// File: tb/tb_reflet_float_latency_tracker.sv
// Directed bench: one tracker in operand-change mode, one in start-strobe mode.
module tb_reflet_float_latency_tracker;

   localparam int unsigned CH    = 4;
   localparam int unsigned IW    = 16;
   localparam int unsigned LW    = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [CH-1:0]    en0, st0, rdy0, dn0, bz0;
   logic [CH*IW-1:0] in0;
   logic [CH*LW-1:0] lat0;
   logic             all0, any0;

   logic [CH-1:0]    en1, st1, rdy1, dn1, bz1;
   logic [CH*IW-1:0] in1;
   logic [CH*LW-1:0] lat1;
   logic             all1, any1;

   int checks = 0;
   int errors = 0;
   int pulses;

   reflet_float_latency_tracker #(.CHANNELS(CH), .INPUT_SIZE(IW), .MAX_LATENCY(8), .TRIGGER_MODE(0)) u_m0 (
      .clk(clk), .reset(reset), .enable(en0), .start(st0), .in(in0), .latency(lat0),
      .ready(rdy0), .done(dn0), .busy(bz0), .all_ready(all0), .any_ready(any0));

   reflet_float_latency_tracker #(.CHANNELS(CH), .INPUT_SIZE(IW), .MAX_LATENCY(8), .TRIGGER_MODE(1)) u_m1 (
      .clk(clk), .reset(reset), .enable(en1), .start(st1), .in(in1), .latency(lat1),
      .ready(rdy1), .done(dn1), .busy(bz1), .all_ready(all1), .any_ready(any1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      en0 = '0; st0 = '0; in0 = '0; lat0 = '0;
      en1 = '0; st1 = '0; in1 = '0; lat1 = '0;
      #12;
      chk("rst_ready0", 32'(rdy0), 0);
      chk("rst_busy0",  32'(bz0),  0);
      chk("rst_any1",   32'(any1), 0);
      chk("rst_all1",   32'(all1), 0);
      tick();
      reset = 1'b1;
      tick();

      // Mode 0: enable rise triggers first; let it settle into READY
      lat0[3:0] = 4'd3;
      en0[0]    = 1'b1;
      repeat (5) tick();
      chk("m0_settled_ready", 32'(rdy0[0]), 1);
      // Operand change 0x0000 -> 0x3C00
      in0[15:0] = 16'h3C00;
      tick();                                   // edge T
      chk("m0_T_ready",  32'(rdy0[0]), 0);
      chk("m0_T_busy",   32'(bz0[0]),  1);
      tick();
      chk("m0_T1_ready", 32'(rdy0[0]), 0);
      tick();
      chk("m0_T2_ready", 32'(rdy0[0]), 0);
      chk("m0_T2_busy",  32'(bz0[0]),  1);
      tick();
      chk("m0_T3_ready", 32'(rdy0[0]), 1);
      chk("m0_T3_done",  32'(dn0[0]),  1);
      chk("m0_T3_busy",  32'(bz0[0]),  0);
      tick();
      chk("m0_T4_done",  32'(dn0[0]),  0);
      chk("m0_T4_ready", 32'(rdy0[0]), 1);

      // Retrigger in COUNT: change at A, again at A+2, ready at A+5
      pulses = 0;
      in0[15:0] = 16'h4000;
      tick();                                   // A
      tick();                                   // A+1
      in0[15:0] = 16'h4200;
      tick();                                   // A+2
      chk("m0_re_A2_ready", 32'(rdy0[0]), 0);
      tick();
      chk("m0_re_A3_ready", 32'(rdy0[0]), 0);
      pulses += int'(dn0[0]);
      tick();
      chk("m0_re_A4_ready", 32'(rdy0[0]), 0);
      pulses += int'(dn0[0]);
      tick();
      chk("m0_re_A5_ready", 32'(rdy0[0]), 1);
      pulses += int'(dn0[0]);
      repeat (3) begin
         tick();
         pulses += int'(dn0[0]);
      end
      chk("m0_re_done_count", 32'(pulses), 1);

      // Enable drop on channel 2 mid-count, then re-raise with unchanged operand
      lat0[11:8] = 4'd4;
      in0[47:32] = 16'h1234;
      en0[2]     = 1'b1;
      tick();                                   // T
      tick();                                   // T+1
      chk("m0_en_busy", 32'(bz0[2]), 1);
      en0[2] = 1'b0;
      tick();                                   // T+2
      chk("m0_drop_busy",  32'(bz0[2]),  0);
      chk("m0_drop_ready", 32'(rdy0[2]), 0);
      chk("m0_drop_done",  32'(dn0[2]),  0);
      tick();
      en0[2] = 1'b1;
      tick();                                   // E
      chk("m0_reen_busy", 32'(bz0[2]), 1);
      repeat (3) tick();                        // E+3
      chk("m0_reen_E3_ready", 32'(rdy0[2]), 0);
      tick();                                   // E+4
      chk("m0_reen_E4_ready", 32'(rdy0[2]), 1);
      chk("m0_reen_E4_done",  32'(dn0[2]),  1);

      // Mode 1: latency 0 behaves as 1
      en1       = 4'b1111;
      lat1[7:4] = 4'd0;
      st1[1]    = 1'b1;
      tick();                                   // T
      st1[1] = 1'b0;
      chk("m1_l0_T_ready", 32'(rdy1[1]), 0);
      chk("m1_l0_T_busy",  32'(bz1[1]),  1);
      tick();
      chk("m1_l0_T1_ready", 32'(rdy1[1]), 1);
      chk("m1_l0_T1_done",  32'(dn1[1]),  1);

      // Mode 1: latency 15 clamps to 8
      lat1[7:4] = 4'd15;
      st1[1]    = 1'b1;
      tick();                                   // T
      st1[1] = 1'b0;
      repeat (7) tick();                        // T+7
      chk("m1_clamp_T7_ready", 32'(rdy1[1]), 0);
      tick();                                   // T+8
      chk("m1_clamp_T8_ready", 32'(rdy1[1]), 1);

      // All channels together, latencies 1,2,4,8
      lat1 = {4'd8, 4'd4, 4'd2, 4'd1};
      st1  = 4'b1111;
      tick();                                   // T
      st1 = '0;
      chk("m1_all_T_ready", 32'(rdy1), 0);
      chk("m1_all_T_busy",  32'(bz1),  32'hF);
      chk("m1_all_T_any",   32'(any1), 0);
      tick();
      chk("m1_all_T1_ready", 32'(rdy1), 32'b0001);
      chk("m1_all_T1_any",   32'(any1), 1);
      chk("m1_all_T1_all",   32'(all1), 0);
      tick();
      chk("m1_all_T2_ready", 32'(rdy1), 32'b0011);
      chk("m1_all_T2_done",  32'(dn1),  32'b0010);
      tick();
      chk("m1_all_T3_ready", 32'(rdy1), 32'b0011);
      tick();
      chk("m1_all_T4_ready", 32'(rdy1), 32'b0111);
      repeat (3) tick();
      chk("m1_all_T7_ready", 32'(rdy1), 32'b0111);
      chk("m1_all_T7_all",   32'(all1), 0);
      tick();
      chk("m1_all_T8_ready", 32'(rdy1), 32'b1111);
      chk("m1_all_T8_all",   32'(all1), 1);
      chk("m1_all_T8_done",  32'(dn1),  32'b1000);

      // Async reset mid-count: outputs clear without a clock edge
      lat1 = {4'd8, 4'd8, 4'd8, 4'd8};
      st1  = 4'b1111;
      tick();
      st1 = '0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_busy1",  32'(bz1),  0);
      chk("rst_mid_ready1", 32'(rdy1), 0);
      chk("rst_mid_ready0", 32'(rdy0), 0);
      chk("rst_mid_busy0",  32'(bz0),  0);
      en0 = '0;
      tick();
      reset = 1'b1;
      pulses = 0;
      repeat (12) begin
         tick();
         pulses += int'(|{rdy1, dn1, rdy0, dn0});
      end
      chk("rst_after_quiet", 32'(pulses), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reflet_float_latency_tracker.md
Name: reflet_float_latency_tracker

Overview:
- Multi-channel successor of the FPU wait-ready helper.
- Each channel tracks one in-flight floating-point operation and raises ready a programmable number of cycles after the operation is triggered.
- The trigger is either an explicit start strobe or a detected operand change.
- Sits between the FPU operator units and the AU sequencer. Each operator gets its own runtime latency, so fast operations no longer pay the worst-case wait.

Parameters:
CHANNELS, 4, number of independent tracking channels
INPUT_SIZE, 16, width of the per-channel operand bus watched in change mode
MAX_LATENCY, 8, largest supported wait in cycles; runtime requests are clamped to it
TRIGGER_MODE, 0, 0 = trigger on operand change, 1 = trigger on start strobe (applies to all channels)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state
enable  input  CHANNELS  per-channel enable; low synchronously idles the channel
start  input  CHANNELS  per-channel start strobe (used only when TRIGGER_MODE=1)
in  input  CHANNELS*INPUT_SIZE  packed operand buses, channel c at [c*INPUT_SIZE +: INPUT_SIZE]
latency  input  CHANNELS*LAT_W  packed requested wait per channel, LAT_W = $clog2(MAX_LATENCY+1)
ready  output  CHANNELS  per-channel result-valid level
done  output  CHANNELS  one-cycle pulse on the cycle ready rises
busy  output  CHANNELS  channel is counting
all_ready  output  1  AND of ready over all channels
any_ready  output  1  OR of ready over all channels

Behaviour:
- Reset (reset=0, asynchronous):
  - All channels go to IDLE.
  - Counters, latched latency and previous-operand registers clear to 0.
  - ready, done and busy are 0; all_ready=0 and any_ready=0.
- Per-channel FSM, states IDLE, COUNT, READY.
- Trigger for channel c, sampled on edge T:
  - TRIGGER_MODE=0: enable[c]=1 and (in_c != prev_in_c, or enable[c] was 0 on the previous edge).
  - TRIGGER_MODE=1: enable[c]=1 and start[c]=1.
- prev_in_c is registered every cycle from in_c, independent of enable.
- On trigger at edge T:
  - Latch L = latency_c, clamped to MAX_LATENCY; L=0 is treated as 1.
  - Load counter with 1; enter COUNT.
  - ready_c is 0 after edge T.
- In COUNT: counter increments each edge. When counter reaches L, the next edge enters READY. Result: ready_c is high after edge T+L and is low after every edge before T+L.
- busy_c is high exactly while in COUNT.
- done_c is high for the single cycle following edge T+L. It is not re-asserted while the channel stays in READY.
- In READY: hold ready_c=1 until the next trigger or until enable_c drops.
- Retrigger, in COUNT or READY: restart from the new T with a freshly latched L. ready and done go 0 at that edge. A trigger on the edge where READY would be entered wins, so no done pulse is produced.
- enable_c=0 at any edge: go to IDLE and clear counter, ready_c, done_c and busy_c. Takes precedence over the trigger and over counting.
- latency_c changes while in COUNT have no effect until the next trigger.
- Counter width is $clog2(MAX_LATENCY+1); it never exceeds MAX_LATENCY and never wraps.
- Channels are fully independent; simultaneous triggers on several channels are all honoured.
- all_ready and any_ready are combinational from the registered ready vector.
- Reset asserted mid-count aborts immediately; no done pulse follows reset release.

Test Plan:
- Mode 0, channel 0: enable=1, latency=3, in changes 0x0000->0x3C00 at edge 10 and then holds → ready0 low through edge 12, high after edge 13; done0 high only in the cycle after edge 13; busy0 high for 3 cycles.
- Mode 0: in changes again at edge 12 with latency=3 → ready0 rises after edge 15, not 13; exactly one done0 pulse.
- Mode 1: start1 pulsed at edge 5 with latency=0 → ready1 high after edge 6; latency=15 with MAX_LATENCY=8 → ready1 high after edge 13.
- Channels 0–3 started together with latencies 1, 2, 4, 8 → ready bits rise at T+1, T+2, T+4, T+8; any_ready high from T+1; all_ready high from T+8.
- enable2 dropped in COUNT at T+2 → ready2, busy2 and done2 low, channel in IDLE. In mode 0, re-raising enable2 at edge E with in unchanged retriggers: ready2 at E+L.
- reset pulsed low mid-count on all channels → all outputs 0 immediately, even without a clock edge; after release, no ready or done until a new trigger.
